// File: rtl/riscv_mem_pkg.sv
// Shared memory-side types for the store buffer: entry layout, lane helpers and widths.
// Address and data widths are fixed here because the entry struct is shared across blocks.
package riscv_mem_pkg;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int BE_W     = DW / 8;
    localparam int WORD_OFS = 2;
    localparam int TAG_W    = AW - WORD_OFS;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    data;
        logic [BE_W-1:0]  be;
    } stbuf_entry_t;

    // Overlay the enabled byte lanes of new_data onto old_data.
    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0]   old_data,
                                                  input logic [DW-1:0]   new_data,
                                                  input logic [BE_W-1:0] be);
        logic [DW-1:0] r;
        r = old_data;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[8*b +: 8] = new_data[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/stbuf_fwd_merge.sv
// Combinational store-to-load forwarding: walks entries oldest to youngest from head so the
// youngest matching entry owns each byte lane.
module stbuf_fwd_merge
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  stbuf_entry_t     entries [DEPTH],
    input  logic [PW-1:0]    head,
    input  logic             ld_valid,
    input  logic [TAG_W-1:0] ld_tag,
    output logic [DW-1:0]    fwd_data,
    output logic [BE_W-1:0]  fwd_mask
);

    logic [PW-1:0] age_idx [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx[i] = head + PW'(i);
        end
    end

    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        if (ld_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[age_idx[i]].valid && (entries[age_idx[i]].tag == ld_tag)) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (entries[age_idx[i]].be[b]) begin
                            fwd_data[8*b +: 8] = entries[age_idx[i]].data[8*b +: 8];
                            fwd_mask[b]        = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM-stage stores and the data-memory write port.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the youngest entry when the word matches.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StValidM,
    input  logic [AW-1:0]   StAddrM,
    input  logic [DW-1:0]   StDataM,
    input  logic [BE_W-1:0] StByteEnM,
    output logic            StReadyM,
    input  logic            LdValidM,
    input  logic [AW-1:0]   LdAddrM,
    output logic [DW-1:0]   LdFwdDataM,
    output logic [BE_W-1:0] LdFwdMaskM,
    output logic            LdStallM,
    input  logic [BE_W-1:0] LdByteEnM,
    output logic            DmWrite,
    output logic [AW-1:0]   DmAddr,
    output logic [DW-1:0]   DmWriteData,
    output logic [BE_W-1:0] DmByteEn,
    input  logic            DmReady,
    output logic            EmptyM
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stbuf_entry_t     entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [TAG_W-1:0] st_tag;
    logic [TAG_W-1:0] ld_tag;
    logic             full;
    logic             drain;
    logic             alloc;
    logic             coalesce;
    logic [BE_W-1:0]  ld_hit_lanes;
    logic             unused_addr_bits;

    assign st_tag           = StAddrM[AW-1:WORD_OFS];
    assign ld_tag           = LdAddrM[AW-1:WORD_OFS];
    assign unused_addr_bits = ^{StAddrM[WORD_OFS-1:0], LdAddrM[WORD_OFS-1:0]};

    assign full    = (count == CW'(DEPTH));
    assign EmptyM  = (count == '0);

    // The head entry is presented to memory whenever anything is buffered.
    assign DmWrite     = !EmptyM;
    assign DmAddr      = {entries[head].tag, {WORD_OFS{1'b0}}};
    assign DmWriteData = entries[head].data;
    assign DmByteEn    = entries[head].be;
    assign drain       = DmWrite && DmReady;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] tail_m1;

    assign tail_m1  = tail - 1'b1;
    // The youngest entry may not absorb a store while it is leaving through the memory port.
    assign coalesce = StValidM && !EmptyM && entries[tail_m1].valid
                      && (entries[tail_m1].tag == st_tag)
                      && !(drain && (head == tail_m1));
    assign StReadyM = !full || coalesce;
`else
    assign coalesce = 1'b0;
    assign StReadyM = !full;
`endif

    assign alloc = StValidM && StReadyM && !coalesce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (alloc) begin
                entries[tail].valid <= 1'b1;
                entries[tail].tag   <= st_tag;
                entries[tail].data  <= StDataM;
                entries[tail].be    <= StByteEnM;
                tail                <= tail + 1'b1;
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (coalesce) begin
                entries[tail_m1].data <= lane_merge(entries[tail_m1].data, StDataM, StByteEnM);
                entries[tail_m1].be   <= entries[tail_m1].be | StByteEnM;
            end
`endif
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            case ({alloc, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The draining head still forwards: memory holds the old word until this edge.
    stbuf_fwd_merge #(
        .DEPTH(DEPTH)
    ) u_fwd (
        .entries  (entries),
        .head     (head),
        .ld_valid (LdValidM),
        .ld_tag   (ld_tag),
        .fwd_data (LdFwdDataM),
        .fwd_mask (LdFwdMaskM)
    );

    assign ld_hit_lanes = LdFwdMaskM & LdByteEnM;
    assign LdStallM     = LdValidM && (ld_hit_lanes != '0) && (ld_hit_lanes != LdByteEnM);

endmodule
